// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared control-path definitions for the fetch redirect controller.
//   state_t          : fetch FSM states (BOOT, RUN, REDIR_PEND)
//   INSTR_BYTES      : sequential fetch stride
//   RESET_PC_DEFAULT : default reset fetch address
//   word_align()     : clears the two low address bits of a redirect target
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        REDIR_PEND = 2'd2
    } state_t;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Hazard-unit / instruction-memory side of the fetch redirect controller.
//   BRANCH_IN, TARGET_IN : taken redirect resolved in EX and its target
//   STALL_IN             : load-use stall request
//   IMEM_BUSY            : instruction memory cannot accept a new fetch
//   PC_OUT, FETCH_VALID  : fetch address and IF/ID capture enable
//   FLUSH_IFID/IDEX      : pipeline register bubble insertion
//   MISALIGN             : sticky misaligned-target flag
//   REDIRECT_COUNT/STALL_COUNT : saturating performance counters
// Modport master drives the hazard inputs; slave is the controller.
interface fetch_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             BRANCH_IN;
    logic [31:0]      TARGET_IN;
    logic             STALL_IN;
    logic             IMEM_BUSY;
    logic [31:0]      PC_OUT;
    logic             FETCH_VALID;
    logic             FLUSH_IFID;
    logic             FLUSH_IDEX;
    logic             MISALIGN;
    logic [CNT_W-1:0] REDIRECT_COUNT;
    logic [CNT_W-1:0] STALL_COUNT;

    modport master (
        output BRANCH_IN, TARGET_IN, STALL_IN, IMEM_BUSY,
        input  PC_OUT, FETCH_VALID, FLUSH_IFID, FLUSH_IDEX,
        input  MISALIGN, REDIRECT_COUNT, STALL_COUNT
    );

    modport slave (
        input  BRANCH_IN, TARGET_IN, STALL_IN, IMEM_BUSY,
        output PC_OUT, FETCH_VALID, FLUSH_IFID, FLUSH_IDEX,
        output MISALIGN, REDIRECT_COUNT, STALL_COUNT
    );
endinterface

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating event counter: counts INC pulses, sticks at all-ones.
//   CLK, RESET_N (async active-low), INC (count enable), COUNT (value)
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            COUNT <= '0;
        end else if (INC && (COUNT != '1)) begin
            COUNT <= COUNT + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-side PC owner. Applies EX redirects, load-use stalls and
// instruction-memory back-pressure to the fetch address, and drives the
// IF/ID and ID/EX flush lines plus the IF/ID capture enable.
//   CLK, RESET_N : clock, async active-low reset
//   bus (slave)  : hazard inputs, fetch address, flushes, status/counters
module fetch_redirect_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    fetch_redirect_ctrl_if.slave bus
);

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pend_target, pend_target_next;
    logic        pend_first, pend_first_next;
    logic        misalign;
    logic        misalign_set;
    logic        fetch_valid, flush_ifid, flush_idex;
    logic        redirect_inc, stall_inc;
    logic [31:0] target_aligned;
    logic        target_misaligned;

    assign target_aligned    = word_align(bus.TARGET_IN);
    assign target_misaligned = |bus.TARGET_IN[1:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pend_target <= '0;
            pend_first  <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pend_target <= pend_target_next;
            pend_first  <= pend_first_next;
            if (misalign_set) begin
                misalign <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        pend_target_next = pend_target;
        pend_first_next  = 1'b0;
        fetch_valid      = 1'b0;
        flush_ifid       = 1'b0;
        flush_idex       = 1'b0;
        redirect_inc     = 1'b0;
        stall_inc        = 1'b0;
        misalign_set     = 1'b0;

        unique case (state)
            BOOT: begin
                state_next = RUN;
            end

            RUN: begin
                // A branch outranks a stall: the stalled ID instruction is
                // on the wrong path and gets flushed anyway.
                if (bus.BRANCH_IN) begin
                    flush_ifid   = 1'b1;
                    flush_idex   = 1'b1;
                    redirect_inc = 1'b1;
                    misalign_set = target_misaligned;
                    if (bus.IMEM_BUSY) begin
                        pend_target_next = target_aligned;
                        pend_first_next  = 1'b1;
                        state_next       = REDIR_PEND;
                    end else begin
                        pc_next = target_aligned;
                    end
                end else if (bus.STALL_IN) begin
                    stall_inc = 1'b1;
                end else if (!bus.IMEM_BUSY) begin
                    fetch_valid = 1'b1;
                    pc_next     = pc + INSTR_BYTES;
                end
            end

            REDIR_PEND: begin
                // Keep IF/ID as a bubble for as long as memory stalls so the
                // wrong-path word is never captured.
                flush_ifid = 1'b1;
                flush_idex = pend_first;
                if (bus.BRANCH_IN) begin
                    pend_target_next = target_aligned;
                    redirect_inc     = 1'b1;
                    misalign_set     = target_misaligned;
                end
                if (!bus.IMEM_BUSY) begin
                    // A branch arriving on the release cycle is the newest
                    // redirect and therefore the one applied.
                    pc_next    = bus.BRANCH_IN ? target_aligned : pend_target;
                    state_next = RUN;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .INC     (redirect_inc),
        .COUNT   (bus.REDIRECT_COUNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .INC     (stall_inc),
        .COUNT   (bus.STALL_COUNT)
    );

    assign bus.PC_OUT      = pc;
    assign bus.FETCH_VALID = fetch_valid;
    assign bus.FLUSH_IFID  = flush_ifid;
    assign bus.FLUSH_IDEX  = flush_idex;
    assign bus.MISALIGN    = misalign;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl. A second instance with 3-bit
// counters shares the same inputs so counter saturation is reached quickly.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        fi;
        logic        fx;
        logic        mis;
        int          rc;
        int          sc;
    } exp_t;

    logic CLK;
    logic RESET_N;

    fetch_redirect_ctrl_if #(.CNT_W(16)) bus ();
    fetch_redirect_ctrl_if #(.CNT_W(3))  bus_s ();

    assign bus_s.BRANCH_IN = bus.BRANCH_IN;
    assign bus_s.TARGET_IN = bus.TARGET_IN;
    assign bus_s.STALL_IN  = bus.STALL_IN;
    assign bus_s.IMEM_BUSY = bus.IMEM_BUSY;

    fetch_redirect_ctrl #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    fetch_redirect_ctrl #(.RESET_PC(RST_PC), .CNT_W(3)) dut_s (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_s.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: what the fetch unit is doing, not how it is encoded.
    logic [31:0] m_pc;
    logic        m_booting;
    logic        m_waiting;      // redirect accepted, memory still busy
    logic        m_wait_fresh;   // first cycle of that wait
    logic [31:0] m_wait_target;
    logic        m_mis;
    int          m_redirects;
    int          m_stalls;

    function automatic int sat(input int raw, input int w);
        int top;
        top = (1 << w) - 1;
        return (raw > top) ? top : raw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pc_out",       bus.PC_OUT,               e.pc);
            check("fetch_valid",  {31'd0, bus.FETCH_VALID}, {31'd0, e.fv});
            check("flush_ifid",   {31'd0, bus.FLUSH_IFID},  {31'd0, e.fi});
            check("flush_idex",   {31'd0, bus.FLUSH_IDEX},  {31'd0, e.fx});
            check("misalign",     {31'd0, bus.MISALIGN},    {31'd0, e.mis});
            check("redirect_cnt", {16'd0, bus.REDIRECT_COUNT}, 32'(sat(e.rc, 16)));
            check("stall_cnt",    {16'd0, bus.STALL_COUNT},    32'(sat(e.sc, 16)));
            check("redirect_cnt_w3", {29'd0, bus_s.REDIRECT_COUNT}, 32'(sat(e.rc, 3)));
            check("stall_cnt_w3",    {29'd0, bus_s.STALL_COUNT},    32'(sat(e.sc, 3)));
            check("pc_out_w3",       bus_s.PC_OUT,                  e.pc);
        end
    end

    task automatic model_reset();
        m_pc          = RST_PC;
        m_booting     = 1'b1;
        m_waiting     = 1'b0;
        m_wait_fresh  = 1'b0;
        m_wait_target = '0;
        m_mis         = 1'b0;
        m_redirects   = 0;
        m_stalls      = 0;
    endtask

    // Hold reset low for one cycle, starting mid-cycle (async assertion).
    task automatic reset_cycle();
        exp_t e;
        @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        model_reset();
        e.pc = RST_PC; e.fv = 1'b0; e.fi = 1'b0; e.fx = 1'b0;
        e.mis = 1'b0; e.rc = 0; e.sc = 0;
        sb.push_back(e);
    endtask

    task automatic step(input logic br, input logic [31:0] tgt, input logic st, input logic busy);
        exp_t        e;
        logic [31:0] aligned;
        @(posedge CLK);
        #1;
        RESET_N       = 1'b1;
        bus.BRANCH_IN = br;
        bus.TARGET_IN = tgt;
        bus.STALL_IN  = st;
        bus.IMEM_BUSY = busy;
        aligned = tgt & 32'hFFFF_FFFC;
        e.pc = m_pc; e.mis = m_mis; e.rc = m_redirects; e.sc = m_stalls;
        e.fv = 1'b0; e.fi = 1'b0; e.fx = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_waiting) begin
            e.fi = 1'b1;
            e.fx = m_wait_fresh;
            m_wait_fresh = 1'b0;
            if (br) begin
                m_wait_target = aligned;
                m_redirects++;
                if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            end
            if (!busy) begin
                m_pc      = m_wait_target;
                m_waiting = 1'b0;
            end
        end else if (br) begin
            e.fi = 1'b1;
            e.fx = 1'b1;
            m_redirects++;
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            if (busy) begin
                m_waiting     = 1'b1;
                m_wait_fresh  = 1'b1;
                m_wait_target = aligned;
            end else begin
                m_pc = aligned;
            end
        end else if (st) begin
            m_stalls++;
        end else if (!busy) begin
            e.fv = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N       = 1'b0;
        bus.BRANCH_IN = 1'b0;
        bus.TARGET_IN = '0;
        bus.STALL_IN  = 1'b0;
        bus.IMEM_BUSY = 1'b0;
        model_reset();

        reset_cycle();
        idle(4);                                   // BOOT, 0x100, 0x104, 0x108
        step(1'b1, 32'h0000_0200, 1'b0, 1'b0);     // plain redirect
        idle(2);
        step(1'b1, 32'h0000_0040, 1'b1, 1'b0);     // branch beats stall
        idle(1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);  // load-use stalls
        idle(1);
        step(1'b1, 32'h0000_0080, 1'b0, 1'b1);     // redirect while memory busy
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);             // busy drops, stall ignored
        idle(2);
        step(1'b1, 32'h0000_0300, 1'b0, 1'b1);     // pending target overwritten
        step(1'b1, 32'h0000_0400, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 32'h0000_0203, 1'b0, 1'b0);     // misaligned target
        idle(3);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);     // address wrap
        idle(3);
        step(1'b1, 32'h0000_0500, 1'b0, 1'b1);     // reset while pending
        step(1'b0, 32'h0, 1'b0, 1'b1);
        reset_cycle();
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            if ($urandom_range(0, 299) == 0) begin
                reset_cycle();
            end else begin
                t = $urandom();
                if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
                step($urandom_range(0, 5) == 0, t,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
            end
        end

        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
